nibble_bus_sram: RTL and testbench

//  Synthesizable, parametrised memory slave for the 8-bit nibble-serial CPU bus (CPU io_out -> memory -> CPU io_in[5:2]).

---
 rtl/nsb_pkg.sv | 19 +
 rtl/nibble_bus_sram_mem.sv | 39 +++
 rtl/nibble_bus_sram.sv | 135 +++++++++++++
 tb/tb_nibble_bus_sram.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nsb_pkg.sv
// Shared definitions for the nibble-serial bus SRAM: cpu_out bit positions,
// bus cycle decode and the address-cycle count helper.
package nsb_pkg;

    localparam int NSB_ADDR_STB = 7;
    localparam int NSB_WRN      = 5;
    localparam int NSB_DSN      = 4;

    typedef enum logic [1:0] {
        CYC_ADDR,
        CYC_READ,
        CYC_WRITE
    } cyc_e;

    function automatic int nsb_addr_cycles(input int addr_w);
        return (addr_w + 6) / 7;
    endfunction

endpackage

// File: rtl/nibble_bus_sram_mem.sv
// Word array for nibble_bus_sram: asynchronous read, two synchronous write
// ports where port a always wins. Out-of-range reads return 0, writes are dropped.
module nsb_mem #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction

    assign rd_data = in_range(rd_addr) ? mem[rd_addr[IDX_W-1:0]] : '0;

    // An enabled port a blocks port b even when its own write is dropped.
    always_ff @(posedge clk) begin
        if (a_en) begin
            if (in_range(a_addr))
                mem[a_addr[IDX_W-1:0]] <= a_data;
        end else if (b_en && in_range(b_addr)) begin
            mem[b_addr[IDX_W-1:0]] <= b_data;
        end
    end

endmodule

// File: rtl/nibble_bus_sram.sv
// Nibble-serial CPU bus memory slave with loader port and optional burst increment.
// Define NSB_WPROT_EN to add the WP_BASE write-protect window and the wp_err pulse.
module nibble_bus_sram
    import nsb_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 128,
    parameter int AUTO_INC = 0
`ifdef NSB_WPROT_EN
    ,
    parameter int WP_BASE  = DEPTH - 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cpu_out,
    output logic [3:0]        nib_out,
    output logic              choose,
    output logic              data_write,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready
`ifdef NSB_WPROT_EN
    ,
    output logic              wp_err
`endif
);

    localparam int NIBS = DATA_W / 4;
    localparam int PH_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int SH_W = (DATA_W > 4) ? DATA_W - 4 : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NIBS - 1);

    cyc_e              cyc;
    logic [ADDR_W-1:0] addr_reg, addr_nxt, addr_shift;
    logic [PH_W-1:0]   phase, phase_nxt, nib_sel;
    logic [SH_W-1:0]   wr_shift, wr_shift_nxt;
    logic [DATA_W-1:0] wr_word, rd_word;
    logic              last, commit_req, cpu_we, wp_hit;

    // Only the low ADDR_W bits of the shifted address survive, so the last chunk is LS.
    if (ADDR_W > 7) begin : g_addr_wide
        assign addr_shift = {addr_reg[ADDR_W-8:0], cpu_out[6:0]};
    end else begin : g_addr_narrow
        assign addr_shift = cpu_out[ADDR_W-1:0];
    end

    if (DATA_W > 4) begin : g_word_multi
        assign wr_word = {wr_shift, cpu_out[3:0]};
    end else begin : g_word_single
        assign wr_word = cpu_out[3:0];
    end

    always_comb begin
        addr_nxt     = addr_reg;
        phase_nxt    = phase;
        wr_shift_nxt = wr_shift;
        commit_req   = 1'b0;
        last         = (phase == PH_LAST);
        if (cpu_out[NSB_ADDR_STB])
            cyc = CYC_ADDR;
        else if (cpu_out[NSB_WRN])
            cyc = CYC_READ;
        else
            cyc = CYC_WRITE;

        unique case (cyc)
            CYC_ADDR: begin
                addr_nxt  = addr_shift;
                phase_nxt = '0;
            end
            CYC_READ, CYC_WRITE: begin
                phase_nxt = last ? '0 : phase + 1'b1;
                if (last && AUTO_INC != 0)
                    addr_nxt = addr_reg + 1'b1;
                if (cyc == CYC_WRITE) begin
                    wr_shift_nxt = wr_word[SH_W-1:0];
                    commit_req   = last;
                end
            end
            default: ;
        endcase
    end

`ifdef NSB_WPROT_EN
    assign wp_hit = commit_req && ({1'b0, addr_reg} >= (ADDR_W + 1)'(WP_BASE));
`else
    assign wp_hit = 1'b0;
`endif

    // A commit that lands in reset is abandoned; the loader then keeps the port.
    assign cpu_we     = commit_req & ~wp_hit & ~rst;
    assign ld_ready   = ~cpu_we;
    assign choose     = phase[0];
    assign data_write = cpu_out[NSB_ADDR_STB] ? 1'b1 : cpu_out[NSB_DSN];
    assign nib_sel    = PH_LAST - phase;
    assign nib_out    = rd_word[{nib_sel, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
            phase    <= '0;
            wr_shift <= '0;
`ifdef NSB_WPROT_EN
            wp_err   <= 1'b0;
`endif
        end else begin
            addr_reg <= addr_nxt;
            phase    <= phase_nxt;
            wr_shift <= wr_shift_nxt;
`ifdef NSB_WPROT_EN
            wp_err   <= wp_hit;
`endif
        end
    end

    nsb_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rd_addr (addr_reg),
        .rd_data (rd_word),
        .a_en    (cpu_we),
        .a_addr  (addr_reg),
        .a_data  (wr_word),
        .b_en    (ld_valid & ld_ready),
        .b_addr  (ld_addr),
        .b_data  (ld_data)
    );

endmodule

// File: tb/tb_nibble_bus_sram.sv
// Scoreboard bench for nibble_bus_sram: a default 128x8 instance and a
// 12-bit-address, 16-bit-word burst instance driven over the nibble bus and loader.
module tb_nibble_bus_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cpu_d, cpu_w;
    logic [3:0]  nib_d, nib_w;
    logic        choose_d, choose_w, dw_d, dw_w;
    logic        ldv_d, ldv_w, rdy_d, rdy_w;
    logic [6:0]  lda_d;
    logic [7:0]  ldd_d;
    logic [11:0] lda_w;
    logic [15:0] ldd_w;
`ifdef NSB_WPROT_EN
    logic        wp_d, wp_w;
`endif

    always #5 clk = ~clk;

`ifdef NSB_WPROT_EN
    nibble_bus_sram #(.WP_BASE(32'h70)) u_dut (
`else
    nibble_bus_sram u_dut (
`endif
        .clk(clk), .rst(rst), .cpu_out(cpu_d), .nib_out(nib_d), .choose(choose_d),
        .data_write(dw_d), .ld_valid(ldv_d), .ld_addr(lda_d), .ld_data(ldd_d),
        .ld_ready(rdy_d)
`ifdef NSB_WPROT_EN
        , .wp_err(wp_d)
`endif
    );

    nibble_bus_sram #(.ADDR_W(12), .DATA_W(16), .DEPTH(256), .AUTO_INC(1)) u_wide (
        .clk(clk), .rst(rst), .cpu_out(cpu_w), .nib_out(nib_w), .choose(choose_w),
        .data_write(dw_w), .ld_valid(ldv_w), .ld_addr(lda_w), .ld_data(ldd_w),
        .ld_ready(rdy_w)
`ifdef NSB_WPROT_EN
        , .wp_err(wp_w)
`endif
    );

    int         n_chk = 0;
    int         n_fail = 0;
    string      tag_q[$];
    logic [3:0] exp_q[$];
    logic       mon_rd = 1'b0;
    int         mon_sel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read nibbles are checked here, half a cycle after they were driven.
    always @(negedge clk) begin
        if (mon_rd) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                automatic string      t = tag_q.pop_front();
                automatic logic [3:0] e = exp_q.pop_front();
                chk(t, 32'(mon_sel != 0 ? nib_w : nib_d), 32'(e));
            end
        end
    end

    task automatic drive(input int sel, input logic [7:0] v, input logic rd,
                         input logic [3:0] exp, input string tag);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            cpu_d = v;
            cpu_w = 8'h30;
        end else begin
            cpu_w = v;
            cpu_d = 8'h30;
        end
        mon_sel = sel;
        mon_rd  = rd;
        if (rd) begin
            tag_q.push_back(tag);
            exp_q.push_back(exp);
        end
    endtask

    task automatic addr(input int sel, input int a, input int ncyc);
        logic [6:0] ch;
        for (int i = ncyc - 1; i >= 0; i--) begin
            ch = 7'((a >> (7 * i)) & 127);
            drive(sel, {1'b1, ch}, 1'b0, 4'h0, "");
        end
    endtask

    task automatic wr(input int sel, input logic [3:0] n);
        drive(sel, {4'b0000, n}, 1'b0, 4'h0, "");
    endtask

    task automatic rd(input int sel, input logic [3:0] exp, input string tag);
        drive(sel, 8'h20, 1'b1, exp, tag);
    endtask

    task automatic idle();
        drive(0, 8'h30, 1'b0, 4'h0, "");
    endtask

    task automatic ld(input int sel, input int a, input int d);
        logic ok;
        int   k;
        @(posedge clk);
        #1;
        cpu_d  = 8'h30;
        cpu_w  = 8'h30;
        mon_rd = 1'b0;
        if (sel == 0) begin
            ldv_d = 1'b1; lda_d = a[6:0]; ldd_d = d[7:0];
        end else begin
            ldv_w = 1'b1; lda_w = a[11:0]; ldd_w = d[15:0];
        end
        @(negedge clk);
        ok = (sel == 0) ? rdy_d : rdy_w;
        k  = 0;
        while (!ok && k < 8) begin
            @(negedge clk);
            ok = (sel == 0) ? rdy_d : rdy_w;
            k++;
        end
        if (!ok) chk("ld_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ldv_d = 1'b0;
        ldv_w = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cpu_d = 8'h30; cpu_w = 8'h30;
        ldv_d = 1'b0; lda_d = '0; ldd_d = '0;
        ldv_w = 1'b0; lda_w = '0; ldd_w = '0;
        repeat (2) @(negedge clk);
        chk("rst_choose_d", 32'(choose_d), 32'd0);
        chk("rst_ready_d", 32'(rdy_d), 32'd1);
        chk("rst_choose_w", 32'(choose_w), 32'd0);
        chk("rst_ready_w", 32'(rdy_w), 32'd1);
`ifdef NSB_WPROT_EN
        chk("rst_wp_d", 32'(wp_d), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // loader preload, then MS-first nibble read
        ld(0, 32'h05, 32'h3C);
        addr(0, 32'h05, 1);
        @(negedge clk);
        chk("dw_addr", 32'(dw_d), 32'd1);
        rd(0, 4'h3, "t1_nib0");
        @(negedge clk);
        chk("dw_data", 32'(dw_d), 32'd0);
        rd(0, 4'hC, "t1_nib1");
        @(negedge clk);
        chk("t1_choose", 32'(choose_d), 32'd1);

        // CPU write, reread twice without increment
        addr(0, 32'h10, 1);
        wr(0, 4'hA);
        wr(0, 4'h5);
        idle();
        @(negedge clk);
        chk("dw_idle", 32'(dw_d), 32'd1);
        addr(0, 32'h10, 1);
        rd(0, 4'hA, "t2_nib0");
        rd(0, 4'h5, "t2_nib1");
        rd(0, 4'hA, "t2_hold0");
        rd(0, 4'h5, "t2_hold1");

        // wide burst write and read back
        ld(1, 32'h000, 32'hBEEF);
        addr(1, 32'h0A0, 2);
        for (int i = 1; i <= 8; i++) wr(1, 4'(i));
        addr(1, 32'h0A0, 2);
        for (int i = 1; i <= 8; i++) rd(1, 4'(i), $sformatf("t3_burst%0d", i));
        // out of range reads zero, address wraps to 0
        addr(1, 32'hFFF, 2);
        for (int i = 0; i < 4; i++) rd(1, 4'h0, "t3_oor");
        rd(1, 4'hB, "t3_wrap0");
        rd(1, 4'hE, "t3_wrap1");
        rd(1, 4'hE, "t3_wrap2");
        rd(1, 4'hF, "t3_wrap3");
        // dropped out-of-range write must not alias onto low memory
        addr(1, 32'h200, 2);
        for (int i = 0; i < 4; i++) wr(1, 4'h9);
        addr(1, 32'h200, 2);
        for (int i = 0; i < 4; i++) rd(1, 4'h0, "t3_drop");
        addr(1, 32'h000, 2);
        rd(1, 4'hB, "t3_alias0");
        rd(1, 4'hE, "t3_alias1");
        rd(1, 4'hE, "t3_alias2");
        rd(1, 4'hF, "t3_alias3");

        // CPU commit collides with loader request
        addr(0, 32'h30, 1);
        wr(0, 4'h1);
        @(posedge clk);
        #1;
        cpu_d = 8'h02;
        mon_rd = 1'b0;
        ldv_d = 1'b1; lda_d = 7'h31; ldd_d = 8'h99;
        @(negedge clk);
        chk("t4_ready_low", 32'(rdy_d), 32'd0);
        @(posedge clk);
        #1;
        cpu_d = 8'h30;
        @(negedge clk);
        chk("t4_ready_high", 32'(rdy_d), 32'd1);
        @(posedge clk);
        #1;
        ldv_d = 1'b0;
        addr(0, 32'h30, 1);
        rd(0, 4'h1, "t4_cpu0");
        rd(0, 4'h2, "t4_cpu1");
        addr(0, 32'h31, 1);
        rd(0, 4'h9, "t4_ld0");
        rd(0, 4'h9, "t4_ld1");

        // reset in the middle of a word write
        ld(0, 32'h20, 32'h77);
        addr(0, 32'h20, 1);
        wr(0, 4'hF);
        @(posedge clk);
        #2;
        chk("t5_choose_pre", 32'(choose_d), 32'd1);
        rst = 1'b1;
        cpu_d = 8'h30;
        #1;
        chk("t5_choose_rst", 32'(choose_d), 32'd0);
        @(posedge clk);
        #1;
        cpu_d = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_d = 8'h30;
        @(negedge clk);
        chk("t5_choose_post", 32'(choose_d), 32'd0);
        addr(0, 32'h20, 1);
        rd(0, 4'h7, "t5_keep0");
        rd(0, 4'h7, "t5_keep1");

`ifdef NSB_WPROT_EN
        // protected window blocks CPU, not the loader
        ld(0, 32'h71, 32'h44);
        addr(0, 32'h71, 1);
        wr(0, 4'h1);
        wr(0, 4'h2);
        idle();
        @(negedge clk);
        chk("t6_wp_pulse", 32'(wp_d), 32'd1);
        idle();
        @(negedge clk);
        chk("t6_wp_clear", 32'(wp_d), 32'd0);
        addr(0, 32'h71, 1);
        rd(0, 4'h4, "t6_blocked0");
        rd(0, 4'h4, "t6_blocked1");
        ld(0, 32'h71, 32'h5A);
        addr(0, 32'h71, 1);
        rd(0, 4'h5, "t6_loader0");
        rd(0, 4'hA, "t6_loader1");
`endif

        idle();
        idle();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
